servo_recarga_ciclos: RTL and testbench

//  Parametrised reload-servo controller and successor to the single-stroke reload block.
//  It drives one hobby servo through N push/return strokes per request (N chosen at run time).
//  It provides abort, busy and debug state, and uses deterministic period-aligned PWM timing.
//  It sits between the turret control unit (issues recarregar) and the reload servo pin.

---
 rtl/servo_recarga_ciclos_pkg.sv | 25 ++
 rtl/servo_recarga_pwm.sv | 54 +++++
 rtl/servo_recarga_ciclos.sv | 141 ++++++++++++++
 tb/tb_servo_recarga_ciclos.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_recarga_ciclos_pkg.sv
// Shared definitions for the multi-stroke reload servo: state codes,
// default timing constants and a width helper.
package servo_recarga_ciclos_pkg;

  // FSM state codes; the numeric value is exported on db_estado.
  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    EMPURRA = 4'd1,
    RETORNA = 4'd2,
    FIM     = 4'd3
  } estado_t;

  // Default timing for a 50 MHz clock and a standard hobby servo.
  localparam int DEF_PWM_PERIOD    = 1_000_000;
  localparam int DEF_PULSE_REPOUSO = 50_000;
  localparam int DEF_PULSE_EMPURRA = 100_000;
  localparam int DEF_T_MOVE        = 25;
  localparam int DEF_MAX_CICLOS    = 4;

  // Bits needed to count 0..valor-1, never less than one bit.
  function automatic int calc_largura(input int valor);
    return (valor > 1) ? $clog2(valor) : 1;
  endfunction

endpackage

// File: rtl/servo_recarga_pwm.sv
// Frame counter and width register for the servo PWM. The output is
// registered so it is low during reset and tracks the next counter value.
module servo_recarga_pwm
  import servo_recarga_ciclos_pkg::*;
#(
  parameter int PWM_PERIOD    = DEF_PWM_PERIOD,
  parameter int PULSE_REPOUSO = DEF_PULSE_REPOUSO,
  parameter int W_PWM         = calc_largura(PWM_PERIOD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W_PWM-1:0] width,
  input  logic             restart,
  output logic             pwm,
  output logic             fim_periodo
);

  localparam logic [W_PWM-1:0] CNT_LAST     = W_PWM'(PWM_PERIOD - 1);
  localparam logic [W_PWM-1:0] LARG_REPOUSO = W_PWM'(PULSE_REPOUSO);

  logic [W_PWM-1:0] cnt_reg, cnt_next;
  logic [W_PWM-1:0] width_reg, width_next;
  logic             pwm_reg, pwm_next;
  logic             wrap;

  // Next counter/width: a new width is only taken at a frame wrap or restart.
  always_comb begin
    wrap       = (cnt_reg == CNT_LAST);
    cnt_next   = cnt_reg + 1'b1;
    width_next = width_reg;
    if (restart || wrap) begin
      cnt_next   = '0;
      width_next = width;
    end
    pwm_next = (cnt_next < width_next);
  end

  // Frame state registers; reset parks the servo at rest with output low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg   <= '0;
      width_reg <= LARG_REPOUSO;
      pwm_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      width_reg <= width_next;
      pwm_reg   <= pwm_next;
    end
  end

  assign pwm         = pwm_reg;
  assign fim_periodo = wrap;

endmodule

// File: rtl/servo_recarga_ciclos.sv
// Reload servo controller: runs N push/return strokes per request, with
// abort, busy flag and a one-cycle done pulse. Phases are frame aligned.
module servo_recarga_ciclos
  import servo_recarga_ciclos_pkg::*;
#(
  parameter int PWM_PERIOD    = DEF_PWM_PERIOD,
  parameter int PULSE_REPOUSO = DEF_PULSE_REPOUSO,
  parameter int PULSE_EMPURRA = DEF_PULSE_EMPURRA,
  parameter int T_MOVE        = DEF_T_MOVE,
  parameter int MAX_CICLOS    = DEF_MAX_CICLOS,
  parameter int W_CICLOS      = $clog2(MAX_CICLOS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                recarregar,
  input  logic [W_CICLOS-1:0] n_ciclos,
  input  logic                abortar,
  output logic                pwm,
  output logic                ocupado,
  output logic                fim_recarga,
  output logic [3:0]          db_estado
);

  localparam int W_PWM  = calc_largura(PWM_PERIOD + 1);
  localparam int W_FASE = calc_largura(T_MOVE * PWM_PERIOD);

  localparam logic [W_FASE-1:0]   FASE_LAST    = W_FASE'(T_MOVE * PWM_PERIOD - 1);
  localparam logic [W_CICLOS-1:0] N_MAX        = W_CICLOS'(MAX_CICLOS);
  localparam logic [W_PWM-1:0]    LARG_REPOUSO = W_PWM'(PULSE_REPOUSO);
  localparam logic [W_PWM-1:0]    LARG_EMPURRA = W_PWM'(PULSE_EMPURRA);

  estado_t             state_reg, state_next;
  logic [W_CICLOS-1:0] ciclo_reg, ciclo_next;
  logic [W_CICLOS-1:0] n_reg, n_next;
  logic                ultimo_reg, ultimo_next;
  logic [W_FASE-1:0]   fase_reg, fase_next;
  logic                restart;
  logic                fim_periodo;
  logic                fim_fase;
  logic [W_PWM-1:0]    largura_alvo;

  // A phase ends on the last clock of its last frame.
  assign fim_fase = fim_periodo && (fase_reg == FASE_LAST);

  // Next-state logic: stroke sequencing, abort marking and phase restarts.
  always_comb begin
    state_next  = state_reg;
    ciclo_next  = ciclo_reg;
    n_next      = n_reg;
    ultimo_next = ultimo_reg;
    fase_next   = '0;
    restart     = 1'b0;
    case (state_reg)
      INICIAL: begin
        if (recarregar && !abortar) begin
          if (n_ciclos == '0) begin
            state_next = FIM;
          end else begin
            state_next  = EMPURRA;
            n_next      = (n_ciclos > N_MAX) ? N_MAX : n_ciclos;
            ciclo_next  = '0;
            ultimo_next = 1'b0;
            restart     = 1'b1;
          end
        end
      end
      EMPURRA: begin
        fase_next = fase_reg + 1'b1;
        if (abortar || fim_fase) begin
          state_next = RETORNA;
          fase_next  = '0;
          restart    = 1'b1;
          if (abortar) begin
            ultimo_next = 1'b1;
          end
        end
      end
      RETORNA: begin
        // The return always runs to completion so the servo ends at rest.
        fase_next = fase_reg + 1'b1;
        if (abortar) begin
          ultimo_next = 1'b1;
        end
        if (fim_fase) begin
          fase_next = '0;
          if ((ciclo_reg + W_CICLOS'(1) < n_reg) && !ultimo_reg && !abortar) begin
            state_next = EMPURRA;
            ciclo_next = ciclo_reg + W_CICLOS'(1);
            restart    = 1'b1;
          end else begin
            state_next = FIM;
          end
        end
      end
      FIM: begin
        state_next = INICIAL;
      end
      default: begin
        state_next = INICIAL;
      end
    endcase
  end

  // Control and datapath registers; reset discards any run in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= INICIAL;
      ciclo_reg  <= '0;
      n_reg      <= '0;
      ultimo_reg <= 1'b0;
      fase_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      ciclo_reg  <= ciclo_next;
      n_reg      <= n_next;
      ultimo_reg <= ultimo_next;
      fase_reg   <= fase_next;
    end
  end

  // Width follows the state being entered so a new phase starts at its own width.
  assign largura_alvo = (state_next == EMPURRA) ? LARG_EMPURRA : LARG_REPOUSO;

  servo_recarga_pwm #(
    .PWM_PERIOD    (PWM_PERIOD),
    .PULSE_REPOUSO (PULSE_REPOUSO),
    .W_PWM         (W_PWM)
  ) u_pwm (
    .clock       (clock),
    .reset       (reset),
    .width       (largura_alvo),
    .restart     (restart),
    .pwm         (pwm),
    .fim_periodo (fim_periodo)
  );

  assign ocupado     = (state_reg != INICIAL);
  assign fim_recarga = (state_reg == FIM);
  assign db_estado   = state_reg;

endmodule

// File: tb/tb_servo_recarga_ciclos.sv
// Bench for servo_recarga_ciclos with short frames. Expected behaviour is
// computed from start offset, stroke count and abort offset by arithmetic.
module tb_servo_recarga_ciclos;

  localparam int P  = 100;
  localparam int PR = 5;
  localparam int PE = 10;
  localparam int T  = 2;
  localparam int MX = 4;
  localparam int TP = T * P;

  logic       clock = 1'b0;
  logic       reset;
  logic       recarregar;
  logic [2:0] n_ciclos;
  logic       abortar;
  logic       pwm;
  logic       ocupado;
  logic       fim_recarga;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  servo_recarga_ciclos #(
    .PWM_PERIOD    (P),
    .PULSE_REPOUSO (PR),
    .PULSE_EMPURRA (PE),
    .T_MOVE        (T),
    .MAX_CICLOS    (MX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .recarregar  (recarregar),
    .n_ciclos    (n_ciclos),
    .abortar     (abortar),
    .pwm         (pwm),
    .ocupado     (ocupado),
    .fim_recarga (fim_recarga),
    .db_estado   (db_estado)
  );

  // Hold reset low for some cycles (checking reset outputs), release, then
  // check a free-running rest PWM whose counter restarts from 1 after release.
  task automatic reset_and_idle(input int cycles, input int idle);
    reset      = 1'b0;
    recarregar = 1'b0;
    abortar    = 1'b0;
    n_ciclos   = 3'd0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clock);
      checks += 4;
      if (pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm cyc=%0d got=%b exp=0", i, pwm); end
      if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado cyc=%0d got=%b exp=0", i, ocupado); end
      if (fim_recarga !== 1'b0) begin failures++; $display("FAIL reset_fim cyc=%0d got=%b exp=0", i, fim_recarga); end
      if (db_estado !== 4'd0) begin failures++; $display("FAIL reset_estado cyc=%0d got=%0d exp=0", i, db_estado); end
    end
    reset = 1'b1;
    for (int j = 1; j <= idle; j++) begin
      @(negedge clock);
      checks += 4;
      if (pwm !== ((j % P) < PR)) begin failures++; $display("FAIL idle_pwm j=%0d got=%b exp=%b", j, pwm, (j % P) < PR); end
      if (ocupado !== 1'b0) begin failures++; $display("FAIL idle_ocupado j=%0d got=%b exp=0", j, ocupado); end
      if (fim_recarga !== 1'b0) begin failures++; $display("FAIL idle_fim j=%0d got=%b exp=0", j, fim_recarga); end
      if (db_estado !== 4'd0) begin failures++; $display("FAIL idle_estado j=%0d got=%0d exp=0", j, db_estado); end
    end
  endtask

  // One request of n strokes started at the next edge k. abort_at>0 raises
  // abortar for edge k+abort_at; stop_at>0 drops reset at edge k+stop_at and
  // ends the run there. noise adds ignored mid-run requests and n changes.
  // Entered and left at a falling edge.
  task automatic drive_run(input int n, input int abort_at, input int stop_at,
                           input int tail, input bit noise);
    int  ne, fim_o, last, p, cnt, hr, exp_st;
    bit  abort_push, push, exp_pwm, exp_ocup, exp_fim;
    ne = (n > MX) ? MX : n;
    abort_push = 1'b0;
    if (ne == 0) begin
      fim_o = 1;
    end else if (abort_at > 0 && abort_at <= 2 * ne * TP) begin
      p = (abort_at - 1) / TP;
      if (p % 2 == 0) begin
        abort_push = 1'b1;
        fim_o = abort_at + TP + 1;
      end else begin
        fim_o = (p + 1) * TP + 1;
      end
    end else begin
      fim_o = 2 * ne * TP + 1;
    end
    last = (stop_at > 0) ? stop_at : fim_o + tail;
    $display("run n=%0d strokes=%0d abort_at=%0d expect_fim_at=k+%0d", n, ne, abort_at, fim_o);
    recarregar = 1'b1;
    n_ciclos   = 3'(n);
    abortar    = 1'b0;
    hr = 0;
    @(negedge clock);
    for (int o = 1; o <= last; o++) begin
      if (o < fim_o) begin
        if (abort_push && o > abort_at) begin
          push = 1'b0;
          cnt  = (o - abort_at - 1) % P;
        end else begin
          push = (((o - 1) / TP) % 2) == 0;
          cnt  = (o - 1) % P;
        end
        exp_pwm  = cnt < (push ? PE : PR);
        exp_ocup = 1'b1;
        exp_fim  = 1'b0;
        exp_st   = push ? 1 : 2;
      end else if (o == fim_o) begin
        exp_pwm  = 1'b1;
        exp_ocup = 1'b1;
        exp_fim  = 1'b1;
        exp_st   = 3;
      end else begin
        exp_pwm  = ((o - fim_o) % P) < PR;
        exp_ocup = 1'b0;
        exp_fim  = 1'b0;
        exp_st   = 0;
      end
      checks += 4;
      if (ne == 0) begin
        hr = pwm ? hr + 1 : 0;
        if (hr > PR) begin failures++; $display("FAIL zero_pwm_run o=%0d got=%0d exp<=%0d", o, hr, PR); end
      end else if (pwm !== exp_pwm) begin
        failures++; $display("FAIL run_pwm n=%0d o=%0d got=%b exp=%b", n, o, pwm, exp_pwm);
      end
      if (ocupado !== exp_ocup) begin failures++; $display("FAIL run_ocupado n=%0d o=%0d got=%b exp=%b", n, o, ocupado, exp_ocup); end
      if (fim_recarga !== exp_fim) begin failures++; $display("FAIL run_fim n=%0d o=%0d got=%b exp=%b", n, o, fim_recarga, exp_fim); end
      if (db_estado !== 4'(exp_st)) begin failures++; $display("FAIL run_estado n=%0d o=%0d got=%0d exp=%0d", n, o, db_estado, exp_st); end
      recarregar = (noise && o <= fim_o) ? ($urandom_range(0, 9) == 0) : 1'b0;
      if (noise) n_ciclos = 3'($urandom_range(0, 7));
      abortar = (o == abort_at);
      reset   = (o == stop_at) ? 1'b0 : 1'b1;
      if (o < last) @(negedge clock);
    end
    recarregar = 1'b0;
    abortar    = 1'b0;
  endtask

  task automatic test_reset;
    reset_and_idle(3, 300);
  endtask

  task automatic test_single;
    drive_run(1, 0, 0, 120, 1'b0);
  endtask

  task automatic test_multi_ignored_requests;
    drive_run(3, 0, 0, 60, 1'b1);
  endtask

  task automatic test_saturate;
    drive_run(7, 0, 0, 60, 1'b0);
  endtask

  task automatic test_zero;
    drive_run(0, 0, 0, 150, 1'b0);
  endtask

  task automatic test_abort;
    drive_run(3, 50, 0, 40, 1'b0);
    drive_run(2, 300, 0, 40, 1'b0);
    drive_run(3, 200, 0, 40, 1'b0);
  endtask

  task automatic test_simultaneous;
    recarregar = 1'b1;
    abortar    = 1'b1;
    n_ciclos   = 3'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      recarregar = 1'b0;
      abortar    = 1'b0;
      checks += 2;
      if (ocupado !== 1'b0) begin failures++; $display("FAIL simult_ocupado cyc=%0d got=%b exp=0", i, ocupado); end
      if (db_estado !== 4'd0) begin failures++; $display("FAIL simult_estado cyc=%0d got=%0d exp=0", i, db_estado); end
    end
  endtask

  task automatic test_back_to_back;
    drive_run(2, 0, 0, 1, 1'b0);
    drive_run(1, 0, 0, 1, 1'b0);
    drive_run(0, 0, 0, 1, 1'b0);
    drive_run(1, 0, 0, 30, 1'b0);
  endtask

  task automatic test_random;
    int n, a, ne;
    for (int r = 0; r < 5; r++) begin
      n  = $urandom_range(0, 7);
      ne = (n > MX) ? MX : n;
      a  = 0;
      if (ne > 0 && $urandom_range(0, 1) == 1) a = $urandom_range(1, 2 * ne * TP);
      drive_run(n, a, 0, $urandom_range(1, 40), 1'b1);
    end
  endtask

  task automatic test_reset_mid;
    drive_run(3, 0, 300, 0, 1'b0);
    reset_and_idle(3, 1700);
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi_ignored_requests;
    test_saturate;
    test_zero;
    test_abort;
    test_simultaneous;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
